// File: rtl/core_sequencer.sv
// rtl/core_sequencer.sv - multi-cycle control FSM for the 16-bit core, one instruction in flight.
// Optional single-step PAUSE state is built only when SEQ_STEP_EN is defined.
module core_sequencer #(
   parameter int PC_W    = 6,
   parameter int ALU_LAT = 1,
   parameter int RET_W   = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             instr_vld,
   input  logic [1:0]       flag,
   input  logic [3:0]       oper,
   input  logic [1:0]       mem_op,
   input  logic             mem_rdy,
   input  logic             step_req,
   output logic [PC_W-1:0]  pc,
   output logic             fetch_en,
   output logic             alu_en,
   output logic             opb_imm,
   output logic             mem_we,
   output logic             mem_dsel,
   output logic             rf_we,
   output logic [1:0]       rf_wsel,
   output logic             rf_wdst_b,
   output logic             halted,
   output logic [RET_W-1:0] retired
);

`ifdef SEQ_STEP_EN
   typedef enum logic [2:0] {
      S_FETCH, S_DECODE, S_EXEC, S_MEMA, S_WB, S_HALT, S_PAUSE
   } state_t;
`else
   typedef enum logic [2:0] {
      S_FETCH, S_DECODE, S_EXEC, S_MEMA, S_WB, S_HALT
   } state_t;
`endif

   typedef enum logic [2:0] {
      C_NOP, C_ALU, C_MOVE, C_LOAD, C_STORE, C_HALT
   } cls_t;

   localparam logic [2:0]       EXEC_LAST = 3'(ALU_LAT - 1);
   localparam logic [PC_W-1:0]  PC_ONE    = PC_W'(1);
   localparam logic [RET_W-1:0] RET_ONE   = RET_W'(1);

   state_t           state, state_nx;
   cls_t             cls_q, d_cls;
   logic             opb_q, wdst_q, dsel_q;
   logic [1:0]       wsel_q;
   logic             d_opb, d_wdst, d_dsel;
   logic [1:0]       d_wsel;
   logic [PC_W-1:0]  pc_q;
   logic [RET_W-1:0] ret_q;
   logic [2:0]       cnt_q;
   logic             run_q;
   logic             mema_first_q;
   logic             accept;
   logic             step_rise;

   // run_q keeps fetch_en low while reset is applied; fetching starts on the first edge after release.
   assign accept = (state == S_FETCH) && run_q && instr_vld;

`ifdef SEQ_STEP_EN
   logic step_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         step_q <= 1'b0;
      end else begin
         step_q <= step_req;
      end
   end

   assign step_rise = step_req && !step_q;
`else
   logic unused_step;

   assign unused_step = step_req;
   assign step_rise   = 1'b0;
`endif

   // Instruction class and datapath selects, decoded from the fields presented with instr_vld.
   always_comb begin
      d_cls  = C_NOP;
      d_opb  = 1'b0;
      d_wdst = 1'b0;
      d_wsel = 2'd0;
      d_dsel = 1'b0;
      case (flag)
         2'd1: begin
            if (oper >= 4'd1 && oper <= 4'hA) begin
               d_cls  = C_ALU;
               d_opb  = (oper >= 4'd6) && (oper <= 4'd9);
               d_wdst = (oper == 4'hA);
            end
         end
         2'd2: begin
            if (oper == 4'd2) begin
               d_cls  = C_MOVE;
               d_wsel = 2'd1;
            end else if (oper == 4'd3) begin
               d_cls  = C_MOVE;
               d_wsel = 2'd2;
            end
         end
         2'd3: begin
            case (mem_op)
               2'd1: begin
                  d_cls  = C_LOAD;
                  d_wsel = 2'd3;
               end
               2'd2: d_cls = C_STORE;
               2'd3: begin
                  d_cls  = C_STORE;
                  d_dsel = 1'b1;
               end
               default: d_cls = C_NOP;
            endcase
         end
         default: begin
            if (oper == 4'hF) begin
               d_cls = C_HALT;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= S_FETCH;
         cls_q        <= C_NOP;
         opb_q        <= 1'b0;
         wdst_q       <= 1'b0;
         wsel_q       <= 2'd0;
         dsel_q       <= 1'b0;
         pc_q         <= '0;
         ret_q        <= '0;
         cnt_q        <= 3'd0;
         run_q        <= 1'b0;
         mema_first_q <= 1'b0;
      end else begin
         state <= state_nx;
         run_q <= 1'b1;
         if (accept) begin
            cls_q  <= d_cls;
            opb_q  <= d_opb;
            wdst_q <= d_wdst;
            wsel_q <= d_wsel;
            dsel_q <= d_dsel;
         end
         if (state == S_DECODE) begin
            cnt_q        <= 3'd0;
            mema_first_q <= 1'b1;
         end else begin
            mema_first_q <= 1'b0;
            if (state == S_EXEC) begin
               cnt_q <= cnt_q + 3'd1;
            end
         end
         if (state == S_WB) begin
            pc_q  <= pc_q + PC_ONE;
            ret_q <= ret_q + RET_ONE;
         end
      end
   end

   always_comb begin
      state_nx  = state;
      fetch_en  = 1'b0;
      alu_en    = 1'b0;
      mem_we    = 1'b0;
      rf_we     = 1'b0;
      halted    = 1'b0;
      case (state)
         S_FETCH: begin
            fetch_en = run_q;
            if (accept) begin
               state_nx = S_DECODE;
            end
         end
         S_DECODE: begin
            case (cls_q)
               C_ALU:            state_nx = S_EXEC;
               C_LOAD, C_STORE:  state_nx = S_MEMA;
               C_HALT:           state_nx = S_HALT;
               default:          state_nx = S_WB;
            endcase
         end
         S_EXEC: begin
            alu_en = 1'b1;
            if (cnt_q == EXEC_LAST) begin
               state_nx = S_WB;
            end
         end
         S_MEMA: begin
            mem_we = mema_first_q && (cls_q == C_STORE);
            if (mem_rdy) begin
               state_nx = S_WB;
            end
         end
         S_WB: begin
            rf_we = (cls_q == C_ALU) || (cls_q == C_MOVE) || (cls_q == C_LOAD);
`ifdef SEQ_STEP_EN
            state_nx = S_PAUSE;
`else
            state_nx = S_FETCH;
`endif
         end
         S_HALT: begin
            halted = 1'b1;
         end
`ifdef SEQ_STEP_EN
         S_PAUSE: begin
            if (step_rise) begin
               state_nx = S_FETCH;
            end
         end
`endif
         default: state_nx = S_FETCH;
      endcase
   end

   assign pc        = pc_q;
   assign retired   = ret_q;
   assign opb_imm   = opb_q;
   assign rf_wdst_b = wdst_q;
   assign rf_wsel   = wsel_q;
   assign mem_dsel  = dsel_q;

endmodule
